// File: rtl/set_time_12_24.sv
// Time-entry editor: loads the 24h time, lets the user step hours/minutes/seconds
// in 12h or 24h display format, and commits the 24h result through a valid/ack handshake.
module set_time_12_24 (
    input  logic        clk,
    input  logic        reset,
    input  logic        mod12_24,
    input  logic [16:0] cur_time,
    input  logic        btn_edit,
    input  logic        btn_next,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        set_ack,
    output logic        editing,
    output logic [1:0]  field,
    output logic [16:0] edit_disp_time,
    output logic        led0,
    output logic [16:0] set_time,
    output logic        set_valid
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EDIT_HR  = 3'd1,
        ST_EDIT_MIN = 3'd2,
        ST_EDIT_SEC = 3'd3,
        ST_COMMIT   = 3'd4
    } state_t;

    // Returns {pm, hour 1..12} for a 24h hour 0..23.
    function automatic logic [5:0] to_12h(input logic [4:0] h24);
        logic [5:0] r;
        if (h24 == 5'd0) begin
            r = {1'b0, 5'd12};
        end else if (h24 < 5'd12) begin
            r = {1'b0, h24};
        end else if (h24 == 5'd12) begin
            r = {1'b1, 5'd12};
        end else begin
            r = {1'b1, h24 - 5'd12};
        end
        return r;
    endfunction

    function automatic logic [4:0] to_24h(input logic pm, input logic [4:0] h12);
        logic [4:0] r;
        if (!pm) begin
            r = (h12 == 5'd12) ? 5'd0 : h12;
        end else begin
            r = (h12 == 5'd12) ? 5'd12 : h12 + 5'd12;
        end
        return r;
    endfunction

    function automatic logic [5:0] step_60(input logic [5:0] v, input logic up);
        logic [5:0] r;
        if (up) begin
            r = (v == 6'd59) ? 6'd0 : v + 6'd1;
        end else begin
            r = (v == 6'd0) ? 6'd59 : v - 6'd1;
        end
        return r;
    endfunction

    // Returns {pm, hour}; in 12h mode the meridiem flips across the 11/12 boundary.
    function automatic logic [5:0] step_hr(input logic mode12, input logic pm,
                                           input logic [4:0] h, input logic up);
        logic [5:0] r;
        if (!mode12) begin
            if (up) begin
                r = {pm, (h == 5'd23) ? 5'd0 : h + 5'd1};
            end else begin
                r = {pm, (h == 5'd0) ? 5'd23 : h - 5'd1};
            end
        end else if (up) begin
            if (h == 5'd11) begin
                r = {~pm, 5'd12};
            end else if (h == 5'd12) begin
                r = {pm, 5'd1};
            end else begin
                r = {pm, h + 5'd1};
            end
        end else begin
            if (h == 5'd12) begin
                r = {~pm, 5'd11};
            end else if (h == 5'd1) begin
                r = {pm, 5'd12};
            end else begin
                r = {pm, h - 5'd1};
            end
        end
        return r;
    endfunction

    state_t      state_r, state_s;
    logic        mode_r, mode_s;
    logic        pm_r, pm_s;
    logic [4:0]  hr_r, hr_s;
    logic [5:0]  min_r, min_s;
    logic [5:0]  sec_r, sec_s;
    logic [16:0] set_time_s;
    logic        set_valid_s;
    logic        editing_s;
    logic [1:0]  field_s;
    logic        inc_s, dec_s;
    logic [4:0]  hr_ld_s;
    logic [5:0]  min_ld_s, sec_ld_s;
    logic [5:0]  hr_ld12_s;
    logic [4:0]  commit_hr_s;

    assign inc_s       = btn_up & ~btn_down;
    assign dec_s       = btn_down & ~btn_up;
    assign hr_ld_s     = (cur_time[16:12] > 5'd23) ? 5'd0 : cur_time[16:12];
    assign min_ld_s    = (cur_time[11:6] > 6'd59) ? 6'd0 : cur_time[11:6];
    assign sec_ld_s    = (cur_time[5:0] > 6'd59) ? 6'd0 : cur_time[5:0];
    assign hr_ld12_s   = to_12h(hr_ld_s);
    assign commit_hr_s = mode_r ? to_24h(pm_r, hr_r) : hr_r;

    // Next-state and next-output computation with edit > next > up/down priority.
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        pm_s        = pm_r;
        hr_s        = hr_r;
        min_s       = min_r;
        sec_s       = sec_r;
        set_time_s  = set_time;
        set_valid_s = set_valid;
        case (state_r)
            ST_IDLE: begin
                set_valid_s = 1'b0;
                if (btn_edit) begin
                    state_s = ST_EDIT_HR;
                    mode_s  = mod12_24;
                    min_s   = min_ld_s;
                    sec_s   = sec_ld_s;
                    if (mod12_24) begin
                        {pm_s, hr_s} = hr_ld12_s;
                    end else begin
                        pm_s = 1'b0;
                        hr_s = hr_ld_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EDIT_HR: begin
                if (btn_edit) begin
                    state_s = ST_IDLE;
                end else if (btn_next) begin
                    state_s = ST_EDIT_MIN;
                end else if (inc_s || dec_s) begin
                    {pm_s, hr_s} = step_hr(mode_r, pm_r, hr_r, inc_s);
                end else begin
                    state_s = ST_EDIT_HR;
                end
            end
            ST_EDIT_MIN: begin
                if (btn_edit) begin
                    state_s = ST_IDLE;
                end else if (btn_next) begin
                    state_s = ST_EDIT_SEC;
                end else if (inc_s || dec_s) begin
                    min_s = step_60(min_r, inc_s);
                end else begin
                    state_s = ST_EDIT_MIN;
                end
            end
            ST_EDIT_SEC: begin
                if (btn_edit) begin
                    state_s = ST_IDLE;
                end else if (btn_next) begin
                    state_s     = ST_COMMIT;
                    set_time_s  = {commit_hr_s, min_r, sec_r};
                    set_valid_s = 1'b1;
                end else if (inc_s || dec_s) begin
                    sec_s = step_60(sec_r, inc_s);
                end else begin
                    state_s = ST_EDIT_SEC;
                end
            end
            ST_COMMIT: begin
                if (set_ack) begin
                    state_s     = ST_IDLE;
                    set_valid_s = 1'b0;
                end else begin
                    state_s = ST_COMMIT;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                set_valid_s = 1'b0;
            end
        endcase

        case (state_s)
            ST_EDIT_HR:  begin editing_s = 1'b1; field_s = 2'd1; end
            ST_EDIT_MIN: begin editing_s = 1'b1; field_s = 2'd2; end
            ST_EDIT_SEC: begin editing_s = 1'b1; field_s = 2'd3; end
            default:     begin editing_s = 1'b0; field_s = 2'd0; end
        endcase
    end

    // State, working fields and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            mode_r         <= 1'b0;
            pm_r           <= 1'b0;
            hr_r           <= 5'd0;
            min_r          <= 6'd0;
            sec_r          <= 6'd0;
            editing        <= 1'b0;
            field          <= 2'd0;
            edit_disp_time <= 17'd0;
            led0           <= 1'b0;
            set_time       <= 17'd0;
            set_valid      <= 1'b0;
        end else begin
            state_r        <= state_s;
            mode_r         <= mode_s;
            pm_r           <= pm_s;
            hr_r           <= hr_s;
            min_r          <= min_s;
            sec_r          <= sec_s;
            editing        <= editing_s;
            field          <= field_s;
            edit_disp_time <= editing_s ? {hr_s, min_s, sec_s} : 17'd0;
            led0           <= editing_s & mode_s & pm_s;
            set_time       <= set_time_s;
            set_valid      <= set_valid_s;
        end
    end

endmodule

// File: doc/set_time_12_24.md
# set_time_12_24

Time-entry editor on the input side of the display path: converts user-edited time in the display format (12h AM/PM or 24h) back to the 17-bit 24h binary time word the clock core stores. On an edit request it loads the current 24h time, converts it to the selected display format and steps through hour, minute and second fields using debounced button pulses. On commit it converts back to 24h and presents the result to the timekeeper or alarm register through a valid/ack handshake. It sits between the button debouncers and the time/alarm registers, alongside the 24h-to-display formatter.

## Interface
Parameters: none. Time word format everywhere: [16:12] hours, [11:6] minutes, [5:0] seconds, unsigned binary.
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- mod12_24  input  1  display mode: 1 = 12h AM/PM, 0 = 24h; sampled only on edit start
- cur_time  input  17  current time in 24h format, loaded on edit start
- btn_edit  input  1  1-cycle pulse: start edit (IDLE) / abort (any edit state)
- btn_next  input  1  1-cycle pulse: advance to next field / commit from seconds field
- btn_up  input  1  1-cycle pulse: increment selected field
- btn_down  input  1  1-cycle pulse: decrement selected field
- set_ack  input  1  consumer accepts set_time while set_valid = 1
- editing  output  1  1 in EDIT_HR, EDIT_MIN, EDIT_SEC
- field  output  2  0 none, 1 hours, 2 minutes, 3 seconds (cursor for blinking)
- edit_disp_time  output  17  working time in latched display format; hours 1..12 in 12h mode
- led0  output  1  PM indicator in 12h editing (1 = PM); 0 otherwise
- set_time  output  17  committed time, 24h format
- set_valid  output  1  commit request, held until acknowledged

## Operation
- States: IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT.
- Per-cycle input priority: btn_edit > btn_next > btn_up/btn_down. If btn_up and btn_down arrive in the same cycle, neither takes effect.
- IDLE + btn_edit → EDIT_HR.
  - mod12_24 is latched into mode_l.
  - cur_time loads into the working registers: hours, minutes and pm flag.
  - Sanitising: hours > 23 load as 0; minutes or seconds > 59 load as 0.
- 24h→12h load conversion: h=0 → 12 AM; 1..11 → h AM; 12 → 12 PM; 13..23 → h−12 PM.
- EDIT_HR stepping, 24h mode: up 23→0, down 0→23.
- EDIT_HR stepping, 12h mode:
  - up: 11→12 and toggles pm; 12→1 without toggle; otherwise +1.
  - down: 12→11 and toggles pm; 1→12 without toggle; otherwise −1.
- EDIT_MIN / EDIT_SEC: 0..59 wrap both directions; no carry or borrow into other fields.
- btn_next transitions: EDIT_HR→EDIT_MIN, EDIT_MIN→EDIT_SEC, EDIT_SEC→COMMIT.
- Entering COMMIT: set_time is loaded with the 12h→24h conversion (12h mode) or the raw hours (24h mode), and set_valid = 1.
  - 12h→24h: 12 AM→0; h AM→h; 12 PM→12; h PM→h+12.
- COMMIT: set_valid and set_time held stable until set_ack = 1. Then the next state is IDLE and set_valid = 0. Buttons are ignored in COMMIT.
- btn_edit in any EDIT_* state → IDLE, discards edits, no set_valid. btn_edit in IDLE starts a new edit.
- mod12_24 changes during editing are ignored until the next edit start.
- IDLE outputs: editing=0, field=0, edit_disp_time=0, led0=0.

## Timing
- All outputs are registered. Reset state: IDLE; editing=0, field=0, edit_disp_time=0, led0=0, set_time=0, set_valid=0.
- Asserting reset at any time, including in COMMIT with set_valid=1, forces the reset state asynchronously. No partial commit survives.
- Button pulse in cycle N → new field value, field and state visible in cycle N+1.
- btn_next in EDIT_SEC at cycle N → set_valid=1 with valid set_time in cycle N+1.
- Handshake: a transfer occurs on a cycle where set_valid=1 and set_ack=1. set_valid is 0 from the next cycle. set_ack while set_valid=0 is ignored.
- Minimum edit-to-commit latency: 4 cycles (btn_edit, then btn_next ×3) plus 1 cycle to set_valid.

## Test plan
- 12h mode, cur_time = 0:30:15, btn_edit → edit_disp_time hours=12, led0=0. Then btn_next ×3 → set_valid=1 with set_time 0:30:15. set_valid holds 5 cycles without ack, drops the cycle after set_ack.
- 12h mode, load 11:00:00, btn_up → hours 12, led0=1. btn_up → hours 1, led0=1. Commit → set_time hours=13.
- 12h mode, load 0:00:00, btn_down → hours 11, led0=1. Commit → set_time 23:00:00.
- 24h mode, load 23:00:59:
  - btn_up → hours 0 (led0=0).
  - btn_next, btn_down → minutes 59.
  - btn_next, btn_up → seconds 0.
  - btn_next → set_time 0:59:00.
- In EDIT_MIN:
  - btn_up+btn_down in the same cycle → no change.
  - Toggle mod12_24 → display format unchanged.
  - btn_edit+btn_next in the same cycle → IDLE, set_valid never asserts.
- Load cur_time hours=27, minutes=63 → working time 0:00:ss. Reset pulse during COMMIT → set_valid=0 and state IDLE immediately.
